// File: rtl/alu_sweep_controller.sv
// Sweeps all 1024 {s,b,a} vectors into a golden and a device ALU, compares
// their results, counts mismatches and captures the first failing vector.
module alu_sweep_controller #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  y_ref,
  input  logic [3:0]  y_dut,
  output logic [3:0]  a,
  output logic [3:0]  b,
  output logic [1:0]  s,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] fail_count,
  output logic [9:0]  first_fail_vec,
  output logic [3:0]  first_y_ref,
  output logic [3:0]  first_y_dut
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [9:0]  vec_q;
  logic [7:0]  dwell_q;
  logic        busy_q, done_q, pass_q;
  logic [10:0] fail_count_q;
  logic [9:0]  first_fail_vec_q;
  logic [3:0]  first_y_ref_q, first_y_dut_q;
  logic        mismatch;

  assign mismatch = (y_ref != y_dut);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      vec_q            <= '0;
      dwell_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      fail_count_q     <= '0;
      first_fail_vec_q <= '0;
      first_y_ref_q    <= '0;
      first_y_dut_q    <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q          <= RUN;
            vec_q            <= '0;
            dwell_q          <= '0;
            busy_q           <= 1'b1;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            fail_count_q     <= '0;
            first_fail_vec_q <= '0;
            first_y_ref_q    <= '0;
            first_y_dut_q    <= '0;
          end
        end
        RUN: begin
          if (dwell_q != DWELL_LAST) begin
            dwell_q <= dwell_q + 8'd1;
          end else begin
            // Results are only trusted on the last dwell cycle of a vector.
            if (mismatch) begin
              fail_count_q <= fail_count_q + 11'd1;
              if (fail_count_q == 11'd0) begin
                first_fail_vec_q <= vec_q;
                first_y_ref_q    <= y_ref;
                first_y_dut_q    <= y_dut;
              end
            end
            if (vec_q == 10'd1023 || (STOP_ON_FAIL && mismatch)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= !mismatch && (fail_count_q == 11'd0);
            end else begin
              vec_q   <= vec_q + 10'd1;
              dwell_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a              = vec_q[3:0];
  assign b              = vec_q[7:4];
  assign s              = vec_q[9:8];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fail_count_q;
  assign first_fail_vec = first_fail_vec_q;
  assign first_y_ref    = first_y_ref_q;
  assign first_y_dut    = first_y_dut_q;

endmodule
